// File: rtl/wb_regfile.sv
// Writeback-stage GPR file plus HI/LO pair with same-cycle write-to-read bypass.
// Define DEBUG_TRACE_EN to add the debug_wb_* trace-comparator outputs.
module wb_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   wb_pc,
    input  logic          wb_regwen,
    input  logic [5:0]    wb_wreg,
    input  logic [DW-1:0] wb_wdata,
    input  logic [1:0]    wb_whilo,
    input  logic [DW-1:0] wb_hi_wdata,
    input  logic [DW-1:0] wb_lo_wdata,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    output logic [DW-1:0] id_rs_data,
    output logic [DW-1:0] id_rt_data,
    output logic [DW-1:0] id_hi,
    output logic [DW-1:0] id_lo
`ifdef DEBUG_TRACE_EN
    ,
    output logic [31:0]   debug_wb_pc,
    output logic [3:0]    debug_wb_rf_wen,
    output logic [4:0]    debug_wb_rf_wnum,
    output logic [31:0]   debug_wb_rf_wdata
`endif
);

    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;

    logic          gpr_wen;
    logic          byp_en;
    logic [4:0]    wnum;

    assign wnum    = wb_wreg[4:0];
    // bit5 of the destination tags HI/LO/CP0-style targets that never touch the GPRs
    assign gpr_wen = wb_regwen && !wb_wreg[5] && (wnum != 5'd0);
    assign byp_en  = !reset;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is cleared in reset because reads must return 0 for every index afterwards.
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (gpr_wen) begin
                rf[wnum] <= wb_wdata;
            end
            if (wb_whilo[1]) begin
                hi_q <= wb_hi_wdata;
            end
            if (wb_whilo[0]) begin
                lo_q <= wb_lo_wdata;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        id_rs_data = '0;
        id_rt_data = '0;
        if (id_rs != 5'd0) begin
            id_rs_data = (byp_en && gpr_wen && (wnum == id_rs)) ? wb_wdata : rf[id_rs];
        end
        if (id_rt != 5'd0) begin
            id_rt_data = (byp_en && gpr_wen && (wnum == id_rt)) ? wb_wdata : rf[id_rt];
        end
    end

    assign id_hi = (byp_en && wb_whilo[1]) ? wb_hi_wdata : hi_q;
    assign id_lo = (byp_en && wb_whilo[0]) ? wb_lo_wdata : lo_q;

`ifdef DEBUG_TRACE_EN
    assign debug_wb_pc       = reset ? 32'd0 : wb_pc;
    assign debug_wb_rf_wen   = reset ? 4'd0  : {4{gpr_wen}};
    assign debug_wb_rf_wnum  = reset ? 5'd0  : wnum;
    assign debug_wb_rf_wdata = reset ? 32'd0 : wb_wdata;
`else
    logic unused_wb_pc;
    assign unused_wb_pc = ^wb_pc;
`endif

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB segment outputs (regwen, wreg, whilo): it holds the architectural GPR file and the HI/LO pair.
- Commits WB-stage writes on the clock edge.
- Serves two combinational GPR read ports plus HI/LO reads to the ID stage, with same-cycle write-to-read bypass so a WB write is visible to ID in the same cycle.

Parameters:
- DW, 32, datapath width for GPRs, HI and LO.
- NREG, 32, number of GPRs; index 0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- wb_pc  in  32  PC of the instruction in WB (used by debug trace only)
- wb_regwen  in  1  GPR write enable from MEM/WB
- wb_wreg  in  6  destination index; bits[4:0] select the GPR; bit5=1 marks a non-GPR destination
- wb_wdata  in  DW  GPR write data
- wb_whilo  in  2  bit1 writes HI, bit0 writes LO
- wb_hi_wdata  in  DW  HI write data
- wb_lo_wdata  in  DW  LO write data
- id_rs  in  5  read port A index
- id_rt  in  5  read port B index
- id_rs_data  out  DW  read port A data
- id_rt_data  out  DW  read port B data
- id_hi  out  DW  current HI value, with bypass
- id_lo  out  DW  current LO value, with bypass

Behaviour:
- **Reset:** with reset=1 at a rising edge, all GPRs, HI and LO clear to 0. Reset has priority over any same-cycle write; that write is dropped. Read outputs after reset are therefore 0 for any index.
- **GPR write:**
  - Qualifying condition: wb_regwen=1, wb_wreg[5]=0 and wb_wreg[4:0]!=0.
  - On the edge, the register at wb_wreg[4:0] takes wb_wdata.
  - All other cases write nothing. This includes wreg=0, wreg[5]=1, and regwen=0 with any wreg.
- **Register 0:** never written; always reads 0, including under bypass.
- **HI/LO write:** on the edge, if wb_whilo[1]=1 then HI <= wb_hi_wdata; if wb_whilo[0]=1 then LO <= wb_lo_wdata. Both bits may be set in the same cycle. HI/LO writes are independent of wb_regwen.
- **Read latency:** 0 cycles (combinational from current state).
- **GPR bypass:** if a qualifying GPR write targets id_rs (or id_rt) in the current cycle, that port outputs wb_wdata instead of the stored value. Both ports may bypass simultaneously when id_rs=id_rt.
- **HI/LO bypass:** id_hi = wb_hi_wdata when wb_whilo[1]=1, else stored HI. id_lo follows the same rule with wb_whilo[0].
- **Reset asserted:** reads show stored state, no bypass. Reset mid-sequence discards all state; the next non-reset cycle behaves as after power-on.
- **No handshake:** one write per cycle. The upstream segment guarantees wb_regwen=0 and wb_whilo=0 for bubbles.
- **Array update:** all array bits are written only on the rising edge; no latches.

Optional Feature:
- **Macro:** DEBUG_TRACE_EN.
- **Defined:** adds four outputs for the trace comparator, all combinational from the WB inputs and forced to 0 while reset=1:
  - debug_wb_pc (32) = wb_pc
  - debug_wb_rf_wen (4) = {4{qualifying GPR write}}
  - debug_wb_rf_wnum (5) = wb_wreg[4:0]
  - debug_wb_rf_wdata (32) = wb_wdata
- **Undefined:** these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then id_rs=5, id_rt=31 with no writes -> both read 0x00000000; id_hi=id_lo=0.
2. Write r5=0x12345678 (regwen=1, wreg=5) with id_rs=5 in the same cycle -> id_rs_data=0x12345678 in that cycle (bypass). Next cycle, with regwen=0 -> still 0x12345678 (stored).
3. Write r0=0xFFFFFFFF, then write with wreg=6'h25 and data 0xDEADBEEF -> r0 reads 0 (bypass included); r5 remains 0x12345678.
4. whilo=2'b11, hi=0xAAAA0001, lo=0x5555_0002 -> id_hi/id_lo show those values the same cycle. Next cycle whilo=2'b10, hi=0x1 -> HI=0x1, LO unchanged at 0x55550002.
5. id_rs=id_rt=9 while writing r9=0xCAFEF00D -> both ports read 0xCAFEF00D. Assert reset together with a write of r9=0x1 -> r9 reads 0 after the edge.
6. With DEBUG_TRACE_EN: write r3=0x77 at wb_pc=0xBFC00010 -> debug_wb_rf_wen=4'hF, wnum=3, wdata=0x77, pc=0xBFC00010. Bubble cycle -> wen=4'h0.
